// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Display back-end of the SpeedTracker CPLD.
//
// A binary speed value is accepted through a valid/ready handshake. A
// sequential double-dabble engine turns it into four BCD digits, which are
// then shown on a 4-digit multiplexed common-anode 7-segment display. The
// digit scan is paced by rising edges of clk_div4. That signal is sampled in
// the clk domain as an enable and is never used as a clock.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   clk_div4     divided clock; each rising edge is one scan tick
//   speed_in     14-bit binary speed value (0..16383)
//   speed_valid  speed_in is valid
//   speed_ready  converter idle and able to accept a value
//   seg_n        segments {g,f,e,d,c,b,a}, active-low
//   dp_n         decimal point, active-low, held off
//   an_n         digit anodes, active-low one-hot, an_n[0] = least significant
//   overflow     displayed value exceeded 9999
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int SCAN_TICKS = 256,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_div4,
    input  logic [13:0] speed_in,
    input  logic        speed_valid,
    output logic        speed_ready,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        overflow
);

    localparam int DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CONV   = 2'b01,
        S_COMMIT = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [13:0]     r_bin;
    logic [15:0]     r_bcd;
    logic [3:0]      r_iter;
    logic            r_ovf_pend;
    logic [15:0]     r_disp;
    logic            r_overflow;
    logic            r_div_q;
    logic [DW-1:0]   r_dwell;
    logic [1:0]      r_idx;
    logic [3:0]      r_an_n;
    logic            w_tick;
    logic [15:0]     w_bcd_adj;
    logic [3:0]      w_digit;
    logic            w_blank;

    // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int k = 0; k < 4; k++) begin
            if (r[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = r[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = r[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Active-low gfedcba pattern of one decimal digit; non-BCD codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Converter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Converter next-state logic: accept, 14 shift iterations, commit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (speed_valid) begin
                    w_next = S_CONV;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CONV: begin
                if (r_iter == 4'd13) begin
                    w_next = S_COMMIT;
                end else begin
                    w_next = S_CONV;
                end
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Converter outputs: ready only while idle.
    always_comb begin
        speed_ready = 1'b0;
        case (r_state)
            S_IDLE:  speed_ready = 1'b1;
            default: speed_ready = 1'b0;
        endcase
    end

    assign w_bcd_adj = bcd_adjust(r_bcd);

    // Double-dabble datapath: capture on accept, correct-and-shift while converting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin      <= 14'd0;
            r_bcd      <= 16'd0;
            r_iter     <= 4'd0;
            r_ovf_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (speed_valid) begin
                        r_bin      <= speed_in;
                        r_bcd      <= 16'd0;
                        r_iter     <= 4'd0;
                        r_ovf_pend <= (speed_in > 14'd9999);
                    end else begin
                        r_bin <= r_bin;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_iter         <= r_iter + 4'd1;
                end
                default: begin
                    r_bin <= r_bin;
                end
            endcase
        end
    end

    // Display register: loaded once per conversion in COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp     <= 16'd0;
            r_overflow <= 1'b0;
        end else if (r_state == S_COMMIT) begin
            r_disp     <= r_bcd;
            r_overflow <= r_ovf_pend;
        end else begin
            r_disp     <= r_disp;
            r_overflow <= r_overflow;
        end
    end

    // div_q resets high so that a clk_div4 already high at reset release
    // does not count; the first tick needs a genuine 0->1 transition.
    assign w_tick = clk_div4 & ~r_div_q;

    // Scan timing: edge detect, dwell count and digit index / anode select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_q <= 1'b1;
            r_dwell <= '0;
            r_idx   <= 2'd0;
            r_an_n  <= 4'b1110;
        end else begin
            r_div_q <= clk_div4;
            if (w_tick) begin
                if (r_dwell == DWELL_LAST) begin
                    r_dwell <= '0;
                    r_idx   <= r_idx + 2'd1;
                    r_an_n  <= ~(4'b0001 << (r_idx + 2'd1));
                end else begin
                    r_dwell <= r_dwell + {{(DW-1){1'b0}}, 1'b1};
                end
            end else begin
                r_dwell <= r_dwell;
            end
        end
    end

    // Select the lit digit and decide whether it is a blanked leading zero.
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit = r_disp[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_digit = r_disp[7:4];
                w_blank = BLANK_LZ && (r_disp[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_disp[11:8];
                w_blank = BLANK_LZ && (r_disp[15:8] == 8'd0);
            end
            2'd3: begin
                w_digit = r_disp[15:12];
                w_blank = BLANK_LZ && (r_disp[15:12] == 4'd0);
            end
            default: begin
                w_digit = 4'd0;
                w_blank = 1'b0;
            end
        endcase
    end

    // Segment drive: overflow dash beats blanking, which beats the digit.
    always_comb begin
        seg_n = 7'b1111111;
        if (r_overflow) begin
            seg_n = 7'b0111111;
        end else if (w_blank) begin
            seg_n = 7'b1111111;
        end else begin
            seg_n = seg_decode(w_digit);
        end
    end

    assign an_n     = r_an_n;
    assign overflow = r_overflow;
    assign dp_n     = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int ST = 2;

    logic        clk;
    logic        rst;
    logic        clk_div4;
    logic [13:0] speed_in;
    logic        speed_valid;
    logic        speed_ready;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [6:0] cap_seg [4];
    bit         cap_seen [4];

    seg_scan_driver #(.SCAN_TICKS(ST), .BLANK_LZ(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_div4    (clk_div4),
        .speed_in    (speed_in),
        .speed_valid (speed_valid),
        .speed_ready (speed_ready),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clk_div4: toggles every 2 clk cycles, driven just after the clk edge
    initial begin
        clk_div4 = 1'b0;
        forever begin
            repeat (2) @(posedge clk);
            #1 clk_div4 = ~clk_div4;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: what digit i should show for accepted value v
    function automatic logic [6:0] exp_seg(input int v, input int i);
        int p;
        int d;
        if (v > 9999) return 7'b0111111;
        p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
        if (i > 0 && v < p) return 7'b1111111;
        d = (v / p) % 10;
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Watch a full scan period and record what each anode showed
    task automatic capture_scan();
        int idx;
        for (int i = 0; i < 4; i++) begin
            cap_seen[i] = 1'b0;
            cap_seg[i]  = 7'h7f;
        end
        repeat (8 * ST * 2 + 4) begin
            @(negedge clk);
            case (an_n)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx >= 0) begin
                cap_seen[idx] = 1'b1;
                cap_seg[idx]  = seg_n;
            end
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!speed_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (speed_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: speed_ready=%b want 1", speed_ready);
        end
    endtask

    task automatic send(input int v);
        @(posedge clk);
        #1;
        speed_in    = 14'(v);
        speed_valid = 1'b1;
        @(posedge clk);
        #1;
        speed_valid = 1'b0;
        wait_ready();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        speed_valid = 1'b0;
        speed_in = 14'd0;
        #20;
        rst = 1'b0;
        #1;
        checks++;
        if ({speed_ready, overflow, dp_n} !== 3'b101) begin
            errors++;
            $display("FAIL reset_flags: ready/ovf/dp=%b want 101", {speed_ready, overflow, dp_n});
        end
        checks++;
        if (an_n !== 4'b1110) begin
            errors++;
            $display("FAIL reset_an: an_n=%b want 1110", an_n);
        end
        checks++;
        if (seg_n !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_seg: seg_n=%b want 1000000", seg_n);
        end
    endtask

    task automatic test_scan();
        int idx;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_div4);
            @(posedge clk);
            @(negedge clk);
            idx = (k / ST) % 4;
            checks++;
            if (an_n !== ~(4'b0001 << idx)) begin
                errors++;
                $display("FAIL scan_an rise %0d: an_n=%b want digit %0d", k, an_n, idx);
            end
            checks++;
            if (seg_n !== exp_seg(0, idx)) begin
                errors++;
                $display("FAIL scan_seg rise %0d: seg_n=%b want %b", k, seg_n, exp_seg(0, idx));
            end
        end
    endtask

    task automatic test_conversion();
        int lo;
        int t;
        @(posedge clk);
        #1;
        speed_in = 14'd1234;
        speed_valid = 1'b1;
        @(posedge clk);
        #1;
        speed_valid = 1'b0;
        lo = 0;
        t = 0;
        @(negedge clk);
        while (!speed_ready && t < 40) begin
            lo++;
            t++;
            @(negedge clk);
        end
        checks++;
        if (lo != 15) begin
            errors++;
            $display("FAIL conv_busy_cycles: got %0d want 15", lo);
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!cap_seen[i] || cap_seg[i] !== exp_seg(1234, i)) begin
                errors++;
                $display("FAIL conv_digit %0d: seen=%b seg=%b want %b", i, cap_seen[i], cap_seg[i], exp_seg(1234, i));
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL conv_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_values(input string name, input int n, input bit rnd);
        int v;
        int fixed_vals [6] = '{7, 105, 10000, 9999, 16383, 0};
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                case ($urandom_range(0, 3))
                    0: v = $urandom_range(10000, 16383);
                    1: v = $urandom_range(0, 150);
                    default: v = $urandom_range(0, 9999);
                endcase
            end else begin
                v = fixed_vals[k];
            end
            send(v);
            capture_scan();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (!cap_seen[i] || cap_seg[i] !== exp_seg(v, i)) begin
                    errors++;
                    $display("FAIL %s value %0d digit %0d: seen=%b seg=%b want %b", name, v, i, cap_seen[i], cap_seg[i], exp_seg(v, i));
                end
            end
            checks++;
            if (overflow !== (v > 9999)) begin
                errors++;
                $display("FAIL %s overflow value %0d: got %b want %b", name, v, overflow, (v > 9999));
            end
        end
    endtask

    task automatic test_busy();
        int t;
        @(posedge clk);
        #1;
        speed_in = 14'd42;
        speed_valid = 1'b1;
        @(posedge clk);
        #1;
        speed_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        speed_in = 14'd77;
        speed_valid = 1'b1;
        @(posedge clk);
        #1;
        speed_valid = 1'b0;
        wait_ready();
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg(42, i)) begin
                errors++;
                $display("FAIL busy_ignore digit %0d: seg=%b want %b", i, cap_seg[i], exp_seg(42, i));
            end
        end
        // 42 again, then 77 held valid until ready returns
        @(posedge clk);
        #1;
        speed_in = 14'd42;
        speed_valid = 1'b1;
        @(posedge clk);
        #1;
        speed_in = 14'd77;
        t = 0;
        @(negedge clk);
        while (!speed_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        speed_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (speed_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold_accept: speed_ready=%b want 0", speed_ready);
        end
        wait_ready();
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg(77, i)) begin
                errors++;
                $display("FAIL busy_hold digit %0d: seg=%b want %b", i, cap_seg[i], exp_seg(77, i));
            end
        end
    endtask

    task automatic test_midreset();
        send(3);
        @(posedge clk);
        #1;
        speed_in = 14'd5678;
        speed_valid = 1'b1;
        @(posedge clk);
        #1;
        speed_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({speed_ready, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_flags: ready/ovf=%b want 10", {speed_ready, overflow});
        end
        repeat (30) @(posedge clk);
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!cap_seen[i] || cap_seg[i] !== exp_seg(0, i)) begin
                errors++;
                $display("FAIL midreset digit %0d: seen=%b seg=%b want %b", i, cap_seen[i], cap_seg[i], exp_seg(0, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_conversion();
        test_values("fixed", 6, 1'b0);
        test_busy();
        test_values("random", 14, 1'b1);
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Display back-end of the SpeedTracker CPLD.
- Accepts a binary speed value through a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine.
- Drives a 4-digit multiplexed common-anode 7-segment display.
- Digit scanning is paced by the ClockDivider output clk_div4, which is sampled in the clk domain as an enable, not used as a clock.

Parameters:
- SCAN_TICKS, 256: number of clk_div4 rising edges each digit stays lit (must be ≥1).
- BLANK_LZ, 1: when 1, leading zeros are blanked; digit 0 is never blanked.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- clk_div4, input, 1: divided clock from ClockDivider; its rising edges are used as scan ticks.
- speed_in, input, 14: binary speed value, 0..16383.
- speed_valid, input, 1: speed_in is valid.
- speed_ready, output, 1: converter idle and able to accept a value.
- seg_n, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp_n, output, 1: decimal point, active-low; held 1.
- an_n, output, 4: digit anodes, active-low, one-hot; an_n[0] is the least-significant digit.
- overflow, output, 1: the displayed value exceeded 9999.

Behaviour:
- Clock and reset:
  - Single clock domain clk; reset rst is asynchronous and active-high.
  - All registers clear on assertion of rst.
- Reset values:
  - speed_ready=1, display digits=0000, overflow=0.
  - Digit index=0, so an_n=4'b1110 and seg_n=7'b1000000 ("0").
  - dp_n=1, dwell counter=0.
- Converter FSM, states IDLE, CONV, COMMIT:
  - IDLE: speed_ready=1. On a clk edge with speed_valid=1, capture speed_in into the shift register, clear the 16-bit BCD accumulator and the iteration counter, and go to CONV. The overflow flag is set if speed_in>9999.
  - CONV: speed_ready=0. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. Exactly 14 iterations (counter 0..13), then go to COMMIT.
  - COMMIT: speed_ready=0. Load the display register with the 4 BCD nibbles and the overflow flag, then return to IDLE.
- Latency:
  - Value accepted at edge N; display register updated at edge N+15; speed_ready returns to 1 after edge N+15.
- speed_valid is ignored while speed_ready=0. No queuing: a new value needs a new valid while ready.
- Reset mid-conversion aborts the conversion. The display returns to "0" and the in-flight value is lost.
- Scan tick:
  - Register div_q <= clk_div4; tick = clk_div4 & ~div_q (one clk cycle per rising edge of clk_div4).
  - The first tick after reset requires a 0→1 transition of clk_div4.
- Dwell counter:
  - Increments on each tick.
  - On the tick where it equals SCAN_TICKS-1, it wraps to 0 and the digit index advances 0→1→2→3→0.
  - an_n is registered and changes in the same cycle as the index.
- Digit decode (combinational from index and display register), active-low gfedcba:
  - 0=1000000
  - 1=1111001
  - 2=0100100
  - 3=0110000
  - 4=0011001
  - 5=0010010
  - 6=0000010
  - 7=1111000
  - 8=0000000
  - 9=0010000
  - Nibbles >9 are unreachable; decode them as all-off (1111111).
- Blanking:
  - Applies when BLANK_LZ=1 and index i>0 and digits i..3 are all zero.
  - A blanked digit outputs seg_n=7'b1111111; the anode is still driven.
- Overflow:
  - When the overflow flag is registered, every digit shows a dash, seg_n=7'b0111111.
  - The overflow output is 1 and stays until the next commit with a value ≤9999.
- Display register update during a scan:
  - New digits appear on the currently lit anode from the next cycle.
  - The scan index and dwell counter are not disturbed.

Test Plan:
- Reset and stimulus: assert rst for 20 ns, then toggle clk_div4 with SCAN_TICKS=2 → speed_ready=1, an_n cycles 1110→1101→1011→0111 every 2 clk_div4 rising edges. seg_n=1000000 on an_n[0]; 1111111 on the other digits.
- Conversion: pulse speed_valid with 1234 → speed_ready low for exactly 15 cycles. Digits: an_n[0] seg_n 0011001 (4), [1] 0110000 (3), [2] 0100100 (2), [3] 1111001 (1). overflow=0.
- Leading-zero blanking: send 7, then 105 → for 7, digit 0 shows 1111000 and digits 1–3 are blank. For 105, digit 1 shows 1000000 (an embedded zero, not blanked) and digit 3 is blank.
- Overflow: send 10000 → all four digits show 0111111 and overflow=1. Then send 9999 → all digits show 0010000 and overflow=0.
- Busy handshake: assert speed_valid with 42, then with 77 during CONV → the second value is ignored and the display shows 42. Holding speed_valid high with 77 until ready is asserted → 77 is accepted at the first ready cycle.
- Reset mid-conversion: assert rst 5 cycles after accepting 5678 → after release the display shows "0", speed_ready=1, and no later commit of 5678 occurs.
